// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and request-legality helper shared by the load/store unit.
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extract/extend for loads and lane merge for sub-word stores.
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];

    unique case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'd0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'd0, half_sel};
      default: rdata_o = word_i;
    endcase

    merged_o = word_i;
    unique case (funct3_i)
      F3_B:    merged_o[{addr_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    merged_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32 byte/half/word loads and stores into whole-word memory accesses,
// using read-modify-write for sub-word stores and rejecting illegal requests without touching memory.
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_data_i
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_err;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  lsu_lane_align u_lane_align (
    .word_i   (mem_data_i),
    .wdata_i  (wdata_q),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .rdata_o  (lane_rdata),
    .merged_o (lane_merged)
  );

  always_comb begin
    req_err = !f3_legal(req_we_i, req_funct3_i)
           || (((req_funct3_i == F3_H) || (req_funct3_i == F3_HU)) && req_addr_i[0])
           || ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00))
           || ((req_addr_i >> ADDR_W) != 32'd0);

    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          f3_d     = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          merged_d = 32'd0;
          rdata_d  = 32'd0;
          err_d    = req_err;
          if (req_err)                  state_d = ST_RESP;
          else if (!req_we_i)           state_d = ST_LOAD;
          else if (req_funct3_i == F3_W) state_d = ST_WRITE;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = lane_rdata;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        merged_d = lane_merged;
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_read_o   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign mem_write_o  = (state_q == ST_WRITE) && we_q;
  assign mem_data_o   = !mem_write_o ? 32'd0 : ((f3_q == F3_W) ? wdata_q : merged_q);

endmodule

`default_nettype wire
